ifetch_queue: RTL and testbench

//  Instruction fetch initiator for the SISC instruction memory.
//  - Owns the fetch PC and drives the IM word address.
//  - Captures the returned 32-bit instruction words into a small prefetch FIFO.
//  - Presents them to decode over a valid/ready handshake.
//  - Supports control-flow redirect (flush and refetch) and halt.

---
 rtl/ifetch_queue.sv | 147 ++++++++++++++
 tb/tb_ifetch_queue.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_queue.sv
// Instruction fetch initiator: owns the fetch PC, buffers returned IM words in a
// small prefetch FIFO and hands them to decode over valid/ready, with redirect and halt.
module ifetch_queue #(
    parameter int unsigned   AW       = 16,
    parameter int unsigned   DW       = 32,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst_f,
    output logic [AW-1:0] im_addr,
    input  logic [DW-1:0] im_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_addr,
    input  logic          halt_req,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [DW-1:0] instr_data,
    output logic [AW-1:0] instr_pc,
    output logic          fetch_idle
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] fetch_pc, fetch_pc_nxt;
    logic [CW-1:0] count, count_nxt;
    logic [PW-1:0] rd_ptr, rd_ptr_nxt;
    logic [PW-1:0] wr_ptr, wr_ptr_nxt;
    logic [AW-1:0] pc_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic          pop;
    logic          push;
    logic          valid_nxt;
    logic          idle_nxt;
    logic [AW-1:0] head_pc_nxt;
    logic [DW-1:0] head_data_nxt;

    // IM address is the fetch PC register itself
    assign im_addr = fetch_pc;

    // Next-state, FIFO bookkeeping and next head contents
    always_comb begin
        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        count_nxt     = count;
        rd_ptr_nxt    = rd_ptr;
        wr_ptr_nxt    = wr_ptr;
        push          = 1'b0;
        pop           = instr_valid & instr_ready;
        head_pc_nxt   = '0;
        head_data_nxt = '0;

        case (state)
            S_IDLE: state_nxt = halt_req ? S_STOP : S_RUN;
            S_RUN: begin
                if (halt_req) begin
                    state_nxt = S_STOP;
                end else begin
                    push = (count < CW'(DEPTH)) || pop;
                end
            end
            S_STOP: begin
                if (!halt_req) begin
                    state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Redirect wins over everything: flush, restart at the new address
        if (redirect_valid) begin
            state_nxt    = S_RUN;
            push         = 1'b0;
            fetch_pc_nxt = redirect_addr;
            count_nxt    = '0;
            rd_ptr_nxt   = '0;
            wr_ptr_nxt   = '0;
        end else begin
            if (push) begin
                fetch_pc_nxt = fetch_pc + AW'(1);
                wr_ptr_nxt   = wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr_nxt = rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_nxt = count + CW'(1);
                2'b01:   count_nxt = count - CW'(1);
                default: count_nxt = count;
            endcase
        end

        // Head bypass when the word being pushed becomes the new head
        if (push && (wr_ptr == rd_ptr_nxt)) begin
            head_pc_nxt   = fetch_pc;
            head_data_nxt = im_data;
        end else begin
            head_pc_nxt   = pc_mem[rd_ptr_nxt];
            head_data_nxt = data_mem[rd_ptr_nxt];
        end

        valid_nxt = (count_nxt != '0);
        idle_nxt  = (state_nxt != S_RUN) && (count_nxt == '0);
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            instr_valid <= 1'b0;
            instr_pc    <= '0;
            instr_data  <= '0;
            fetch_idle  <= 1'b1;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            count       <= count_nxt;
            rd_ptr      <= rd_ptr_nxt;
            wr_ptr      <= wr_ptr_nxt;
            instr_valid <= valid_nxt;
            instr_pc    <= head_pc_nxt;
            instr_data  <= head_data_nxt;
            fetch_idle  <= idle_nxt;
        end
    end

    // FIFO storage; contents are qualified by count so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= im_data;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_ifetch_queue;

    localparam int DEPTH = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;

    logic        clk;
    logic        rst_f;
    logic [15:0] im_addr;
    logic [31:0] im_data;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        halt_req;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [15:0] instr_pc;
    logic        fetch_idle;

    int total;
    int bad;

    // reference model state
    logic [15:0] mq_pc[$];
    logic [31:0] mq_data[$];
    logic [15:0] m_pc;
    int          m_mode;

    typedef struct {
        logic        rv;
        logic [15:0] ra;
        logic        h;
        logic        rdy;
        logic        e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_addr;
        logic        e_idle;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [31:0] im_word(input logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    assign im_data = im_word(im_addr);

    ifetch_queue #(
        .AW(16), .DW(32), .DEPTH(DEPTH), .RESET_PC(16'h0000)
    ) dut (
        .clk(clk),
        .rst_f(rst_f),
        .im_addr(im_addr),
        .im_data(im_data),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .halt_req(halt_req),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data(instr_data),
        .instr_pc(instr_pc),
        .fetch_idle(fetch_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("valid", 32'(instr_valid), 32'(mq_pc.size() != 0));
        if (mq_pc.size() != 0) begin
            chk("head_pc", 32'(instr_pc), 32'(mq_pc[0]));
            chk("head_data", instr_data, mq_data[0]);
        end
        chk("im_addr", 32'(im_addr), 32'(m_pc));
        chk("fetch_idle", 32'(fetch_idle), 32'((m_mode != M_RUN) && (mq_pc.size() == 0)));
    endtask

    // one clock: drive inputs, advance the model, then compare after the edge
    task automatic step(input logic rv, input logic [15:0] ra, input logic h, input logic rdy);
        int  sz;
        logic popped;
        redirect_valid = rv;
        redirect_addr  = ra;
        halt_req       = h;
        instr_ready    = rdy;
        sz     = mq_pc.size();
        popped = (sz != 0) && rdy;
        if (rv) begin
            mq_pc.delete();
            mq_data.delete();
            m_pc   = ra;
            m_mode = M_RUN;
        end else begin
            if (popped) begin
                void'(mq_pc.pop_front());
                void'(mq_data.pop_front());
            end
            if (m_mode == M_IDLE) begin
                m_mode = h ? M_STOP : M_RUN;
            end else if (m_mode == M_RUN) begin
                if (h) begin
                    m_mode = M_STOP;
                end else if (sz < DEPTH || popped) begin
                    mq_pc.push_back(m_pc);
                    mq_data.push_back(im_word(m_pc));
                    m_pc = m_pc + 16'd1;
                end
            end else if (!h) begin
                m_mode = M_RUN;
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_f          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        halt_req       = 1'b0;
        instr_ready    = 1'b0;
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_pc", 32'(instr_pc), 32'd0);
        chk("rst_data", instr_data, 32'd0);
        chk("rst_idle", 32'(fetch_idle), 32'd1);
        chk("rst_addr", 32'(im_addr), 32'd0);
        mq_pc.delete();
        mq_data.delete();
        m_pc   = 16'h0000;
        m_mode = M_IDLE;
        @(posedge clk);
        @(negedge clk);
        rst_f = 1'b1;
    endtask

    initial begin
        logic        h_r;
        logic [15:0] frozen;
        total = 0;
        bad   = 0;
        rst_f = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = '0;
        halt_req       = 1'b0;
        instr_ready    = 1'b0;

        // startup latency, steady streaming, redirect wrap across FFFF
        tbl[0] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0};
        tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0};
        tbl[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0002, 1'b0};
        tbl[3] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0002, 16'h0003, 1'b0};
        tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0003, 16'h0004, 1'b0};
        tbl[5] = '{1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFE, 1'b0};
        tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hFFFE, 16'hFFFF, 1'b0};
        tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b0};
        tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0001, 1'b0};
        tbl[9] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0002, 1'b0};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rv, tbl[i].ra, tbl[i].h, tbl[i].rdy);
            chk($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_addr", i), 32'(im_addr), 32'(tbl[i].e_addr));
            chk($sformatf("tbl%0d_idle", i), 32'(fetch_idle), 32'(tbl[i].e_idle));
            if (tbl[i].e_valid) begin
                chk($sformatf("tbl%0d_pc", i), 32'(instr_pc), 32'(tbl[i].e_pc));
                chk($sformatf("tbl%0d_data", i), instr_data, im_word(tbl[i].e_pc));
            end
        end

        // backpressure until full, then drain with no gaps or duplicates
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("full_addr", 32'(im_addr), 32'h4);
        chk("full_head", 32'(instr_pc), 32'h0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("drain_pc%0d", k), 32'(instr_pc), 32'(k));
            step(1'b0, 16'h0, 1'b0, 1'b1);
        end

        // redirect with three queued entries
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("pre_redir_addr", 32'(im_addr), 32'h3);
        step(1'b1, 16'h0040, 1'b0, 1'b0);
        chk("redir_bubble", 32'(instr_valid), 32'd0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("redir_valid", 32'(instr_valid), 32'd1);
        chk("redir_pc", 32'(instr_pc), 32'h40);
        chk("redir_data", instr_data, im_word(16'h0040));
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

        // halt with two entries queued, drain, then release
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
        frozen = im_addr;
        for (int i = 0; i < 5; i++) step(1'b0, 16'h0, 1'b1, 1'b1);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_idle", 32'(fetch_idle), 32'd1);
        chk("halt_addr", 32'(im_addr), 32'h2);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("resume_pc", 32'(instr_pc), 32'(frozen));

        // reset mid-stream with a full queue
        for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("restart_pc", 32'(instr_pc), 32'h0);

        // randomized traffic against the model, starting with halt out of reset
        do_reset();
        h_r = 1'b1;
        for (int i = 0; i < 600; i++) begin
            logic        rv;
            logic [15:0] ra;
            rv = ($urandom_range(0, 15) == 0);
            ra = ($urandom_range(0, 1) == 1) ? 16'(16'hFFFC + 16'($urandom_range(0, 3)))
                                             : 16'($urandom);
            if ($urandom_range(0, 9) == 0) h_r = ~h_r;
            step(rv, ra, h_r, ($urandom_range(0, 3) != 0));
            if (i == 300) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
